// File: rtl/alu_exec_seq.sv
// alu_exec_seq: sequenced EX-stage ALU with a valid/ready handshake.
// Single-cycle add/sub/and/or/nor/slt/jr decode, iterative shift (one bit
// per cycle) and iterative shift-add multiply (one multiplier bit per cycle).
// Optional feature macro: ALU_EXEC_FAST_SHIFT_EN -- when defined, sll/srl
// use a single-cycle barrel shifter and the SHIFT state is never entered.
module alu_exec_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUOp,
  input  logic [5:0]         Funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               jr,
  output logic               sign,
  output logic               illegal,
  output logic               busy
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_MULT = 6'd24;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;
  typedef enum logic [1:0] {K_SINGLE, K_SHIFT, K_MUL} kind_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               jr_q, jr_d;
  logic               sign_q, sign_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   acc_q, acc_d;       // shift operand or product accumulator
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, shifted right each step
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // remaining iterations
  logic               left_q, left_d;     // shift direction: 1 = sll, 0 = srl

  // Decode results for the request currently on the inputs
  kind_e              dec_kind;
  logic [WIDTH-1:0]   dec_res;
  logic               dec_jr, dec_sign, dec_ill, dec_left;
  logic [WIDTH-1:0]   shift_step;
  logic [WIDTH-1:0]   mul_step;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign jr        = jr_q;
  assign sign      = sign_q;
  assign illegal   = illegal_q;

  // Decode ALUOp/Funct into an immediate result or a multi-cycle op kind
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (no latches).
    dec_kind = K_SINGLE;
    dec_res  = '0;
    dec_jr   = 1'b0;
    dec_sign = 1'b0;
    dec_ill  = 1'b0;
    dec_left = 1'b0;
    unique case (ALUOp)
      2'b00: dec_res = a + b;
      2'b01: dec_res = a - b;
      2'b11: begin
        dec_res  = a & b;
        dec_sign = 1'b1;
      end
      default: begin
        unique case (Funct)
          F_ADD: dec_res = a + b;
          F_SUB: dec_res = a - b;
          F_AND: begin
            dec_res  = a & b;
            dec_sign = 1'b1;
          end
          F_OR:  dec_res = a | b;
          F_NOR: dec_res = ~(a | b);
          F_SLT: dec_res = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
          F_JR: begin
            dec_res = a;
            dec_jr  = 1'b1;
          end
          F_MULT: dec_kind = K_MUL;
`ifdef ALU_EXEC_FAST_SHIFT_EN
          F_SLL: dec_res = b << shamt;
          F_SRL: dec_res = b >> shamt;
`else
          F_SLL: begin
            if (shamt == '0) begin
              dec_res = b;
            end else begin
              dec_kind = K_SHIFT;
              dec_left = 1'b1;
            end
          end
          F_SRL: begin
            if (shamt == '0) begin
              dec_res = b;
            end else begin
              dec_kind = K_SHIFT;
            end
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // One iteration of the shift and multiply datapaths
  always_comb begin
    shift_step = left_q ? (acc_q << 1) : (acc_q >> 1);
    mul_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and datapath update for the IDLE/SHIFT/MUL/DONE sequencer
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    jr_d      = jr_q;
    sign_d    = sign_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          jr_d      = dec_jr;
          sign_d    = dec_sign;
          illegal_d = dec_ill;
          unique case (dec_kind)
            K_SHIFT: begin
              acc_d   = b;
              cnt_d   = {1'b0, shamt};
              left_d  = dec_left;
              state_d = SHIFT;
            end
            K_MUL: begin
              acc_d    = '0;
              mcand_d  = a;
              mplier_d = b;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = MUL;
            end
            default: begin
              result_d = dec_res;
              zero_d   = (dec_res == '0);
              state_d  = DONE;
            end
          endcase
        end
      end
      SHIFT: begin
        acc_d = shift_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = shift_step;
          zero_d   = (shift_step == '0);
          state_d  = DONE;
        end
      end
      MUL: begin
        acc_d    = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = mul_step;
          zero_d   = (mul_step == '0);
          state_d  = DONE;
        end
      end
      default: begin // DONE: hold everything until the consumer takes it
        if (out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      jr_q      <= 1'b0;
      sign_q    <= 1'b0;
      illegal_q <= 1'b0;
      // NOTE: the working registers are reset too; they are a handful of
      // flops, not a memory array, so a known value costs nothing.
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      jr_q      <= jr_d;
      sign_q    <= sign_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq: the driver pushes the hand-computed
// response on accept, the monitor pops and compares on each output handshake.
module tb_alu_exec_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         ALUOp;
  logic [5:0]         Funct;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   a, b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero, jr, sign, illegal, busy;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             jr;
    logic             sg;
    logic             il;
    int               lat;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic ov_prev = 1'b0;
  logic hs_prev = 1'b0;

  alu_exec_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .jr(jr), .sign(sign), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on out_valid rise, full response on handshake
  always @(negedge clk) begin
    if (reset) begin
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("in_ready_after_handshake", in_ready, 1);
      hs_prev = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!ov_prev) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
          check("in_ready_low_in_done", in_ready, 0);
          if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("zero", zero, e.z);
            check("jr", jr, e.jr);
            check("sign", sign, e.sg);
            check("illegal", illegal, e.il);
            hs_prev = 1'b1;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  function automatic int shift_lat(input int sh);
`ifdef ALU_EXEC_FAST_SHIFT_EN
    return 1;
`else
    return (sh == 0) ? 1 : 1 + sh;
`endif
  endfunction

  // Drive one request; when do_push is set, the expected response is queued on accept
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input int sh,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic [WIDTH-1:0] res, input logic ejr, input logic esg,
                       input logic eil, input int lat, input bit do_push);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    in_valid = 1'b1;
    ALUOp = op; Funct = fn; shamt = SHAMT_W'(sh); a = va; b = vb;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    if (do_push) begin
      e.res = res; e.z = (res == '0); e.jr = ejr; e.sg = esg; e.il = eil;
      e.lat = lat; e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("completion_timeout", 0, 1);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; Funct = '0; shamt = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, jr, sign, illegal, busy}, 0);

    // op, funct, shamt, a, b, expected result, jr, sign, illegal, latency
    issue(2'b10, 6'd32, 0, 32'd5, 32'd7, 32'd12, 0, 0, 0, 1, 1);                    wait_done();
    issue(2'b10, 6'd42, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 1, 1);             wait_done();
    issue(2'b10, 6'd42, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 1, 1);             wait_done();
    issue(2'b01, 6'd0, 0, 32'd9, 32'd9, 32'd0, 0, 0, 0, 1, 1);                      wait_done();
    issue(2'b00, 6'd63, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 1, 1);             wait_done();
    issue(2'b10, 6'd0, 4, 32'd0, 32'd1, 32'h10, 0, 0, 0, shift_lat(4), 1);           wait_done();
    issue(2'b10, 6'd0, 0, 32'd0, 32'd1, 32'd1, 0, 0, 0, shift_lat(0), 1);            wait_done();
    issue(2'b10, 6'd2, 3, 32'd0, 32'h8000_0080, 32'h1000_0010, 0, 0, 0, shift_lat(3), 1); wait_done();
    issue(2'b10, 6'd0, 31, 32'd0, 32'd3, 32'h8000_0000, 0, 0, 0, shift_lat(31), 1);  wait_done();
    issue(2'b10, 6'd24, 0, 32'h1_0000, 32'h1_0003, 32'h3_0000, 0, 0, 0, 33, 1);      wait_done();
    issue(2'b10, 6'd24, 0, 32'd7, 32'd6, 32'd42, 0, 0, 0, 33, 1);                    wait_done();
    issue(2'b10, 6'd8, 0, 32'h400, 32'd0, 32'h400, 1, 0, 0, 1, 1);                   wait_done();
    issue(2'b10, 6'd63, 0, 32'd5, 32'd6, 32'd0, 0, 0, 1, 1, 1);                      wait_done();
    issue(2'b11, 6'd0, 0, 32'hF0F0, 32'hFF00, 32'hF000, 0, 1, 0, 1, 1);              wait_done();
    issue(2'b10, 6'd36, 0, 32'h0F0F, 32'h00FF, 32'h000F, 0, 1, 0, 1, 1);             wait_done();
    issue(2'b10, 6'd37, 0, 32'h0F00, 32'h00F0, 32'h0FF0, 0, 0, 0, 1, 1);             wait_done();
    issue(2'b10, 6'd39, 0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 1);              wait_done();
    issue(2'b10, 6'd34, 0, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 0, 1, 1);              wait_done();

    // Reset part-way through a multiply: no result may appear
    issue(2'b10, 6'd24, 0, 32'h1_0000, 32'h1_0003, 32'd0, 0, 0, 0, 0, 0);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", seen, 0);

    // Back-pressure: hold DONE for 5 cycles with a new request waiting
    @(posedge clk); #1 out_ready = 1'b0;
    issue(2'b00, 6'd0, 0, 32'd1, 32'd2, 32'd3, 0, 0, 0, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_out_valid_seen", seen, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; ALUOp = 2'b00; a = 32'd10; b = 32'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_result_held", result, 32'd3);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); // handshake cycle for the first request
    @(negedge clk);
    check("bp_accept_after_handshake", in_ready, 1);
    begin
      exp_t e;
      e.res = 32'd30; e.z = 1'b0; e.jr = 1'b0; e.sg = 1'b0; e.il = 1'b0;
      e.lat = 1; e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
